// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad scanner: column strobing, press/release debounce and a two-digit key history.
// Define KEY_REPEAT_EN to build auto-repeat while a key is held.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV        = 4800,
  parameter int unsigned DEBOUNCE_CYCLES = 960000,
  parameter int unsigned REPEAT_CYCLES   = 24000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       busy
);

  localparam int unsigned MaxAb  = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned MaxCnt = (MaxAb > REPEAT_CYCLES) ? MaxAb : REPEAT_CYCLES;
  localparam int unsigned CW     = $clog2(MaxCnt) + 1;

  localparam logic [CW-1:0] ScanLast = CW'(SCAN_DIV - 1);
  // Entry into the debounce state already accounts for one stable sample.
  localparam logic [CW-1:0] DebLast  = CW'(DEBOUNCE_CYCLES - 2);
  // Rows reflect a new strobe only after the synchronizer has flushed (needs SCAN_DIV >= 3).
  localparam logic [CW-1:0] Settle   = CW'(2);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RepLast  = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StScan,
    StDebounce,
    StConfirm,
    StHeld,
    StReleaseDb
  } state_t;

  state_t        state_q;
  logic [3:0]    sync1_q;
  logic [3:0]    rs_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    cidx_q;
  logic [1:0]    lrow_q;
  logic [1:0]    lcol_q;
`ifdef KEY_REPEAT_EN
  logic [CW-1:0] rep_q;
`endif

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] x);
    return (x == '1) ? x : x + CW'(1);
  endfunction

  assign cols = ~(4'b0001 << cidx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StScan;
      sync1_q   <= 4'hF;
      rs_q      <= 4'hF;
      cnt_q     <= '0;
      cidx_q    <= 2'd0;
      lrow_q    <= 2'd0;
      lcol_q    <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      digit0    <= 4'h0;
      digit1    <= 4'h0;
      busy      <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      sync1_q   <= rows;
      rs_q      <= sync1_q;
      key_valid <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (cnt_q >= Settle && rs_q != 4'hF) begin
            lrow_q  <= low_row(rs_q);
            lcol_q  <= cidx_q;
            cnt_q   <= '0;
            state_q <= StDebounce;
            busy    <= 1'b1;
          end else if (cnt_q == ScanLast) begin
            cnt_q  <= '0;
            cidx_q <= cidx_q + 2'd1;
          end else begin
            cnt_q <= inc(cnt_q);
          end
        end
        StDebounce: begin
          if (rs_q[lrow_q]) begin
            cnt_q   <= '0;
            state_q <= StScan;
            busy    <= 1'b0;
          end else if (cnt_q == DebLast) begin
            cnt_q   <= '0;
            state_q <= StConfirm;
          end else begin
            cnt_q <= inc(cnt_q);
          end
        end
        StConfirm: begin
          cnt_q <= '0;
          if (!rs_q[lrow_q] && $countones(~rs_q) == 1) begin
            key_code  <= keymap(lrow_q, lcol_q);
            digit0    <= keymap(lrow_q, lcol_q);
            digit1    <= digit0;
            key_valid <= 1'b1;
            state_q   <= StHeld;
`ifdef KEY_REPEAT_EN
            rep_q     <= '0;
`endif
          end else begin
            state_q <= StScan;
            busy    <= 1'b0;
          end
        end
        StHeld: begin
          // Only the latched row matters; the frozen strobe hides other columns.
          if (rs_q[lrow_q]) begin
            cnt_q   <= '0;
            state_q <= StReleaseDb;
`ifdef KEY_REPEAT_EN
            rep_q   <= '0;
          end else if (rep_q == RepLast) begin
            rep_q     <= '0;
            key_code  <= keymap(lrow_q, lcol_q);
            digit0    <= keymap(lrow_q, lcol_q);
            digit1    <= digit0;
            key_valid <= 1'b1;
          end else begin
            rep_q <= inc(rep_q);
`endif
          end
        end
        StReleaseDb: begin
          if (!rs_q[lrow_q]) begin
            cnt_q   <= '0;
            state_q <= StHeld;
`ifdef KEY_REPEAT_EN
            rep_q   <= '0;
`endif
          end else if (cnt_q == DebLast) begin
            cnt_q   <= '0;
            cidx_q  <= cidx_q + 2'd1;
            state_q <= StScan;
            busy    <= 1'b0;
          end else begin
            cnt_q <= inc(cnt_q);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StScan;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl; rows are driven directly as a keypad would pull them.
// Expected pulses and history come from press/hold durations and the key table.
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DC = 16;
  localparam int RC = 64;
`ifdef KEY_REPEAT_EN
  localparam bit Rep = 1'b1;
`else
  localparam bit Rep = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       busy;

  int checks = 0;
  int passed = 0;
  int npulse = 0;

  logic [3:0] m_code = 4'h0;
  logic [3:0] m_d0 = 4'h0;
  logic [3:0] m_d1 = 4'h0;
  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'hE, 4'h0, 4'hF, 4'hD}};

  keypad_scan_ctrl #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_CYCLES   (RC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .digit0    (digit0),
    .digit1    (digit1),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (key_valid === 1'b1) npulse++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Wait until the strobe has just moved onto column c; returns right after that edge.
  task automatic align(input int c, output bit ok);
    logic [3:0] want;
    logic [3:0] prev;
    want = ~(4'b0001 << c);
    prev = cols;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (cols === want && prev !== want) begin
        ok = 1'b1;
        break;
      end
      prev = cols;
    end
    checks++;
    if (!ok) $display("FAIL align: cols=%b never moved to %b", cols, want);
    else passed++;
  endtask

  task automatic run_press(input int r, input int c, input int len);
    bit ok, acc, ep, eb;
    logic [3:0] ec;
    align(c, ok);
    if (!ok) return;
    rows = ~(4'b0001 << r);
    acc = (len >= DC + 1);
    for (int k = 1; k <= len + DC + 6; k++) begin
      @(posedge clk); #1;
      ep = acc && k >= DC + 3 && ((k - DC - 3) % RC == 0) && (k == DC + 3 || (Rep && k <= len + 2));
      eb = (k >= 3) && (acc ? (k <= len + DC + 1) : (k <= len + 2));
      if (ep) begin
        m_d1 = m_d0;
        m_d0 = kmap[r][c];
        m_code = kmap[r][c];
      end
      checks++;
      if (key_valid !== ep)
        $display("FAIL press_valid r%0d c%0d len%0d cyc%0d: key_valid=%b want %b",
                 r, c, len, k, key_valid, ep);
      else passed++;
      checks++;
      if (busy !== eb)
        $display("FAIL press_busy r%0d c%0d len%0d cyc%0d: busy=%b want %b",
                 r, c, len, k, busy, eb);
      else passed++;
      if (ep) begin
        checks++;
        if ({key_code, digit1, digit0} !== {m_code, m_d1, m_d0})
          $display("FAIL press_data cyc%0d: code/d1/d0=%h%h%h want %h%h%h",
                   k, key_code, digit1, digit0, m_code, m_d1, m_d0);
        else passed++;
      end
      if (k == (acc ? len + DC + 2 : len + 3)) begin
        ec = ~(4'b0001 << (acc ? (c + 1) % 4 : c));
        checks++;
        if (cols !== ec) $display("FAIL press_cols_resume len%0d: cols=%b want %b", len, cols, ec);
        else passed++;
      end
      if (k == len) rows = 4'hF;
    end
    checks++;
    if ({key_code, digit1, digit0} !== {m_code, m_d1, m_d0})
      $display("FAIL press_hist r%0d c%0d len%0d: code/d1/d0=%h%h%h want %h%h%h",
               r, c, len, key_code, digit1, digit0, m_code, m_d1, m_d0);
    else passed++;
  endtask

  task automatic test_reset();
    int idx;
    reset = 1'b1;
    rows = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cols, key_code, key_valid, digit0, digit1, busy} !== {4'b1110, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0})
      $display("FAIL reset_state: cols=%b code=%h kv=%b d0=%h d1=%h busy=%b",
               cols, key_code, key_valid, digit0, digit1, busy);
    else passed++;
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      idx = (k / SD) % 4;
      checks++;
      if (cols !== ~(4'b0001 << idx) || key_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL scan_rotate cyc%0d: cols=%b kv=%b busy=%b want cols=%b kv=0 busy=0",
                 k, cols, key_valid, busy, ~(4'b0001 << idx));
      else passed++;
    end
  endtask

  task automatic test_press5();
    run_press(1, 1, 60);
  endtask

  task automatic test_bounce();
    run_press(2, 3, 6);
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = npulse;
    run_press(0, 2, 40);
    repeat (18) @(posedge clk);
    run_press(0, 3, 40);
    checks++;
    if (npulse - n0 !== 2 || digit1 !== 4'h3 || digit0 !== 4'hA)
      $display("FAIL back_to_back: pulses=%0d d1=%h d0=%h want 2 3 A", npulse - n0, digit1, digit0);
    else passed++;
  endtask

  // Hold 5; 8 shares its column, 1 sits in a column that stays unstrobed.
  task automatic test_multi_key();
    bit ok, ep, eb;
    int last;
    logic [3:0] ec;
    last = 50;
    align(1, ok);
    if (!ok) return;
    rows = 4'b1101;
    for (int k = 1; k <= 71; k++) begin
      @(posedge clk); #1;
      ep = (k == DC + 3);
      eb = (k >= 3) && (k <= last + DC + 1);
      ec = (k <= last + DC + 1) ? 4'b1101 : 4'b1011;
      if (ep) begin
        m_d1 = m_d0;
        m_d0 = kmap[1][1];
        m_code = kmap[1][1];
      end
      checks++;
      if (key_valid !== ep || busy !== eb || cols !== ec)
        $display("FAIL multi_key cyc%0d: kv=%b busy=%b cols=%b want %b %b %b",
                 k, key_valid, busy, cols, ep, eb, ec);
      else passed++;
      case (k)
        25: rows = 4'b1001;
        35: rows = 4'b1101;
        40: rows = 4'hF;
        43: rows = 4'b1101;
        50: rows = 4'hF;
        default: ;
      endcase
    end
    checks++;
    if ({key_code, digit1, digit0} !== {m_code, m_d1, m_d0})
      $display("FAIL multi_key_hist: %h%h%h want %h%h%h",
               key_code, digit1, digit0, m_code, m_d1, m_d0);
    else passed++;
  endtask

  task automatic test_multirow();
    bit ok;
    align(1, ok);
    if (!ok) return;
    rows = 4'b1001;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      checks++;
      if (key_valid !== 1'b0) $display("FAIL multirow_valid cyc%0d: key_valid=%b want 0", k, key_valid);
      else passed++;
      if (k == 30) rows = 4'hF;
    end
    checks++;
    if ({busy, key_code, digit1, digit0} !== {1'b0, m_code, m_d1, m_d0})
      $display("FAIL multirow_end: busy=%b hist=%h%h%h want 0 %h%h%h",
               busy, key_code, digit1, digit0, m_code, m_d1, m_d0);
    else passed++;
  endtask

  task automatic test_random();
    int r, c, len, sel;
    for (int t = 0; t < 12; t++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      case (sel)
        0: len = $urandom_range(1, DC - 1);
        1: len = DC;
        2: len = DC + 1;
        default: len = $urandom_range(DC + 2, 40);
      endcase
      run_press(r, c, len);
    end
  endtask

  task automatic test_hold_long();
    int n0;
    n0 = npulse;
    run_press(3, 2, 200);
    checks++;
    if (npulse - n0 !== (Rep ? 3 : 1))
      $display("FAIL hold_long_pulses: %0d want %0d", npulse - n0, Rep ? 3 : 1);
    else passed++;
  endtask

  task automatic reset_pulse(input string tag);
    int n0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_code = 4'h0;
    m_d0 = 4'h0;
    m_d1 = 4'h0;
    checks++;
    if ({cols, key_code, key_valid, digit0, digit1, busy} !== {4'b1110, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0})
      $display("FAIL %s_async: cols=%b code=%h kv=%b d0=%h d1=%h busy=%b",
               tag, cols, key_code, key_valid, digit0, digit1, busy);
    else passed++;
    repeat (3) @(posedge clk);
    rows = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    n0 = npulse;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (key_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL %s_after cyc%0d: kv=%b busy=%b want 0 0", tag, k, key_valid, busy);
      else passed++;
    end
    checks++;
    if (npulse != n0 || {digit1, digit0} !== 8'h00)
      $display("FAIL %s_nopulse: pulses=%0d digits=%h%h want 0 00", tag, npulse - n0, digit1, digit0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    align(2, ok);
    if (ok) begin
      rows = 4'b0111;
      repeat (8) @(posedge clk);
      reset_pulse("reset_debounce");
    end
    run_press(1, 0, 30);
    align(2, ok);
    if (ok) begin
      rows = 4'b0111;
      for (int k = 1; k <= 30; k++) begin
        @(posedge clk); #1;
        if (k == DC + 3) begin
          m_d1 = m_d0;
          m_d0 = kmap[3][2];
          m_code = kmap[3][2];
        end
      end
      checks++;
      if ({busy, key_code, digit1, digit0} !== {1'b1, m_code, m_d1, m_d0})
        $display("FAIL held_before_reset: busy=%b hist=%h%h%h want 1 %h%h%h",
                 busy, key_code, digit1, digit0, m_code, m_d1, m_d0);
      else passed++;
      reset_pulse("reset_held");
    end
  endtask

  initial begin
    test_reset();
    test_press5();
    test_bounce();
    test_back_to_back();
    test_multi_key();
    test_multirow();
    test_random();
    test_hold_long();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
